// File: rtl/calc_entry.sv
// -----------------------------------------------------------------------------
// calc_entry
//
// Key-entry stage of the stopwatch-calculator. Sits directly after the keypad
// scanner and takes one debounced key code per press. It builds two decimal
// operands and one operator from those keys. The finished command goes to the
// arithmetic stage over a valid/ready handshake. The operand being typed is
// also exposed for the 7-segment display path.
//
// Optional feature macro: CALC_ENTRY_BACKSPACE_EN
//   Defined     : '*' with digits typed removes the last digit (acc/10).
//                 '*' with no digits typed does a full clear.
//   Not defined : '*' always does a full clear, and no divider is built.
//   In ISSUE, '*' always aborts the pending command.
//
// Parameters
//   DIGITS : maximum decimal digits per operand (1..7)
//   W      : operand width; 10**DIGITS - 1 must fit in W bits
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_valid   in   one-cycle strobe qualifying key_code
//   key_code    in   0-9 digit, 10-13 A/B/C/D = add/sub/mul/div,
//                    14 '#' = equals, 15 '*' = clear
//   cmd_valid   out  command available (registered)
//   cmd_ready   in   consumer accepts the command
//   operand_a   out  first operand, unsigned binary
//   operand_b   out  second operand, unsigned binary
//   opcode      out  0 add, 1 sub, 2 mul, 3 div
//   entry_value out  value currently being typed
//   entry_count out  digits typed in the current operand
//   phase       out  0 ENTER_A, 1 ENTER_B, 2 ISSUE
// -----------------------------------------------------------------------------
module calc_entry #(
    parameter int DIGITS = 4,
    parameter int W      = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   opcode,
    output logic [W-1:0] entry_value,
    output logic [2:0]   entry_count,
    output logic [1:0]   phase
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

    localparam logic [3:0] KEY_EQUALS = 4'd14;
    localparam logic [3:0] KEY_STAR   = 4'd15;

    state_t       state_reg;
    logic [W-1:0] acc_reg;
    logic [2:0]   count_reg;
    logic [W-1:0] operand_a_reg;
    logic [W-1:0] operand_b_reg;
    logic [1:0]   opcode_reg;
    logic         cmd_valid_reg;

    // Key decode.
    logic       is_digit;
    logic       is_operator;
    logic       is_equals;
    logic       is_star;
    logic [3:0] op_index;

    // Next-value terms.
    logic [W-1:0] acc_append_next;
    logic [W-1:0] acc_backspace_next;
    logic         digit_accept;
    logic         backspace_now;
    logic         full_clear;

    always_comb begin
        is_digit    = (key_code <= 4'd9);
        is_operator = (key_code >= 4'd10) && (key_code <= 4'd13);
        is_equals   = (key_code == KEY_EQUALS);
        is_star     = (key_code == KEY_STAR);
        op_index    = key_code - 4'd10;
    end

    // acc*10 + d written as shifts and adds.
    // The result cannot overflow W bits. A digit is only appended while
    // count < DIGITS, so acc < 10**(DIGITS-1) at that point.
    always_comb begin
        acc_append_next = (acc_reg << 3) + (acc_reg << 1) + {{(W-4){1'b0}}, key_code};
    end

    // A leading zero is dropped. The display then stays at 0, and the digit
    // does not use up one of the DIGITS positions.
    always_comb begin
        digit_accept = key_valid && is_digit
                    && (count_reg != MAX_COUNT)
                    && !((key_code == 4'd0) && (count_reg == 3'd0));
    end

`ifdef CALC_ENTRY_BACKSPACE_EN
    always_comb begin
        acc_backspace_next = acc_reg / W'(10);
        backspace_now      = key_valid && is_star && (state_reg != ISSUE)
                          && (count_reg != 3'd0);
    end
`else
    always_comb begin
        acc_backspace_next = acc_reg;
        backspace_now      = 1'b0;
    end
`endif

    // One flag covers every route back to a clean ENTER_A:
    //   - a completed handshake;
    //   - '*' in ISSUE (abort);
    //   - '*' while typing, unless it acts as a backspace.
    // '*' and cmd_ready in the same cycle in ISSUE still transfer the
    // command. The consumer has sampled it, and the end state is the same.
    always_comb begin
        full_clear = 1'b0;
        if (state_reg == ISSUE) begin
            full_clear = (cmd_valid_reg && cmd_ready) || (key_valid && is_star);
        end else begin
            full_clear = key_valid && is_star && !backspace_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ENTER_A;
            acc_reg       <= '0;
            count_reg     <= 3'd0;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
            opcode_reg    <= 2'd0;
            cmd_valid_reg <= 1'b0;
        end else if (full_clear) begin
            state_reg     <= ENTER_A;
            acc_reg       <= '0;
            count_reg     <= 3'd0;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
            opcode_reg    <= 2'd0;
            cmd_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ENTER_A, ENTER_B: begin
                    if (digit_accept) begin
                        acc_reg   <= acc_append_next;
                        count_reg <= count_reg + 3'd1;
                    end else if (backspace_now) begin
                        acc_reg   <= acc_backspace_next;
                        count_reg <= count_reg - 3'd1;
                    end else if (key_valid && is_operator) begin
                        if (state_reg == ENTER_A) begin
                            // An empty first operand is allowed and means 0.
                            operand_a_reg <= acc_reg;
                            opcode_reg    <= op_index[1:0];
                            acc_reg       <= '0;
                            count_reg     <= 3'd0;
                            state_reg     <= ENTER_B;
                        end else if (count_reg == 3'd0) begin
                            // The user changed their mind before typing B.
                            opcode_reg <= op_index[1:0];
                        end
                    end else if (key_valid && is_equals && (state_reg == ENTER_B)) begin
                        // acc is kept so the display still shows operand B
                        // while the command waits for the consumer.
                        operand_b_reg <= acc_reg;
                        cmd_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The command stays frozen until a handshake or an abort.
                    // Both are handled by full_clear above.
                    cmd_valid_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ENTER_A;
                    cmd_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_reg;
    assign operand_a   = operand_a_reg;
    assign operand_b   = operand_b_reg;
    assign opcode      = opcode_reg;
    assign entry_value = acc_reg;
    assign entry_count = count_reg;
    assign phase       = state_reg;

endmodule

// File: tb/tb_calc_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_entry
//
// Self-checking bench for calc_entry (DIGITS=4, W=14).
// - A vector table gives key sequences and the entry state expected after
//   them.
// - Hand-written sequences cover the multi-cycle cases: handshake latency,
//   holding under back-pressure, abort, simultaneous '*' and ready, a burst
//   of keys on consecutive cycles, and an asynchronous reset.
// - Each command is pushed to a scoreboard queue when '#' is typed, and
//   popped and compared when the DUT completes the handshake.
// -----------------------------------------------------------------------------
module tb_calc_entry;

    localparam int DIGITS = 4;
    localparam int W      = 14;

`ifdef CALC_ENTRY_BACKSPACE_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [1:0]   opcode;
    logic [W-1:0] entry_value;
    logic [2:0]   entry_count;
    logic [1:0]   phase;

    calc_entry #(.DIGITS(DIGITS), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .opcode      (opcode),
        .entry_value (entry_value),
        .entry_count (entry_count),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } cmd_t;

    cmd_t sb[$];

    typedef struct {
        int          n;
        logic [31:0] keys;   // first key in the top nibble
        int          value;
        int          count;
        int          ph;
        int          opa;
        int          op;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One strobe. The key is set up at the falling edge and sampled at the
    // next rising edge. The task returns 1 ns after that edge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input int a, input int b, input int op);
        cmd_t c;
        c.a  = W'(a);
        c.b  = W'(b);
        c.op = 2'(op);
        sb.push_back(c);
    endtask

    task automatic handshake(input string name);
        bit   seen;
        cmd_t e;
        seen = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cmd_valid) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s: command seen, scoreboard empty", name);
                end else begin
                    e = sb.pop_front();
                    check({name, "_opa"}, 32'(operand_a), 32'(e.a));
                    check({name, "_opb"}, 32'(operand_b), 32'(e.b));
                    check({name, "_op"},  32'(opcode),    32'(e.op));
                    $display("cmd %s: a=%0d b=%0d op=%0d", name, operand_a, operand_b, opcode);
                end
                @(posedge clk);
                #1;
                cmd_ready = 1'b0;
                check({name, "_valid_after"}, 32'(cmd_valid),   0);
                check({name, "_phase_after"}, 32'(phase),       0);
                check({name, "_value_after"}, 32'(entry_value), 0);
                check({name, "_opa_after"},   32'(operand_a),   0);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            cmd_ready = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, cmd_valid 0 after 20 cycles", name);
        end
    endtask

    initial begin
        cmd_t e;

        // Keys are listed from the top nibble down, one nibble per key.
        tbl[0]  = '{7, 32'h00123450, 1234, 4, 0, 0, 0};   // leading zeros and a 5th digit ignored
        tbl[1]  = '{3, 32'h12A00000, 0, 0, 1, 12, 0};
        tbl[2]  = '{4, 32'h99990000, 9999, 4, 0, 0, 0};   // largest value that fits
        tbl[3]  = '{1, 32'hA0000000, 0, 0, 1, 0, 0};      // operator with an empty A
        tbl[4]  = '{2, 32'h4E000000, 4, 1, 0, 0, 0};      // '#' ignored in ENTER_A
        tbl[5]  = '{4, 32'h5A070000, 7, 1, 1, 5, 0};      // leading zero dropped in B
        tbl[6]  = '{4, 32'h5A3B0000, 3, 1, 1, 5, 0};      // operator ignored once B has digits
        tbl[7]  = '{2, 32'h7C000000, 0, 0, 1, 7, 2};
        tbl[8]  = '{4, 32'h123F0000, BS ? 12 : 0, BS ? 2 : 0, 0, 0, 0};
        tbl[9]  = '{5, 32'h123FF000, BS ? 1 : 0,  BS ? 1 : 0, 0, 0, 0};
        tbl[10] = '{3, 32'h4AF00000, 0, 0, 0, 0, 0};      // '*' with count 0 is a full clear
        tbl[11] = '{3, 32'h1D200000, 2, 1, 1, 1, 3};

        // While reset is asserted, every output is 0.
        #2;
        check("rst_valid", 32'(cmd_valid),   0);
        check("rst_opa",   32'(operand_a),   0);
        check("rst_opb",   32'(operand_b),   0);
        check("rst_op",    32'(opcode),      0);
        check("rst_value", 32'(entry_value), 0);
        check("rst_count", 32'(entry_count), 0);
        check("rst_phase", 32'(phase),       0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            for (int j = 0; j < tbl[v].n; j++) begin
                press(tbl[v].keys[(7 - j) * 4 +: 4]);
            end
            check($sformatf("vec%0d_value", v), 32'(entry_value), tbl[v].value);
            check($sformatf("vec%0d_count", v), 32'(entry_count), tbl[v].count);
            check($sformatf("vec%0d_phase", v), 32'(phase),       tbl[v].ph);
            check($sformatf("vec%0d_opa", v),   32'(operand_a),   tbl[v].opa);
            check($sformatf("vec%0d_op", v),    32'(opcode),      tbl[v].op);
            check($sformatf("vec%0d_valid", v), 32'(cmd_valid),   0);
            $display("vec %0d: value=%0d count=%0d phase=%0d", v, entry_value, entry_count, phase);
        end

        // 12 + 3, then '#' and a handshake. cmd_valid rises one cycle after '#'.
        do_reset();
        press(4'd1); press(4'd2); press(4'd10); press(4'd3);
        press(4'd14);
        push_cmd(12, 3, 0);
        check("add_valid_latency", 32'(cmd_valid), 1);
        check("add_phase_issue",   32'(phase),     2);
        handshake("add");

        // 7 * 8 held for 5 cycles while 9s are pressed, then accepted.
        press(4'd7); press(4'd12); press(4'd8); press(4'd14);
        push_cmd(7, 8, 2);
        for (int i = 0; i < 5; i++) begin
            press(4'd9);
            check($sformatf("hold%0d_valid", i), 32'(cmd_valid), 1);
            check($sformatf("hold%0d_opa", i),   32'(operand_a), 7);
            check($sformatf("hold%0d_opb", i),   32'(operand_b), 8);
            check($sformatf("hold%0d_op", i),    32'(opcode),    2);
        end
        press(4'd10);
        press(4'd14);
        check("hold_op_after_keys", 32'(opcode), 2);
        handshake("mul_hold");

        // Operator replaced at count 0; later operator ignored.
        press(4'd5); press(4'd10); press(4'd11); press(4'd4); press(4'd13); press(4'd14);
        push_cmd(5, 4, 1);
        handshake("replace_op");

        // Abort with '*' in ISSUE. Nothing is pushed to the scoreboard.
        press(4'd3); press(4'd10); press(4'd3); press(4'd14);
        check("abort_pre_valid", 32'(cmd_valid), 1);
        press(4'd15);
        check("abort_valid", 32'(cmd_valid), 0);
        check("abort_phase", 32'(phase),     0);
        check("abort_opa",   32'(operand_a), 0);
        check("abort_opb",   32'(operand_b), 0);
        check("abort_op",    32'(opcode),    0);

        // '*' and cmd_ready in the same cycle: the command still transfers.
        press(4'd2); press(4'd11); press(4'd1); press(4'd14);
        push_cmd(2, 1, 1);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd15;
        cmd_ready = 1'b1;
        check("simul_valid_before", 32'(cmd_valid), 1);
        e = sb.pop_front();
        check("simul_opa", 32'(operand_a), 32'(e.a));
        check("simul_opb", 32'(operand_b), 32'(e.b));
        check("simul_op",  32'(opcode),    32'(e.op));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        check("simul_valid_after", 32'(cmd_valid), 0);
        check("simul_phase_after", 32'(phase),     0);
        check("simul_opa_after",   32'(operand_a), 0);

        // Strobes on back-to-back cycles.
        @(negedge clk); key_valid = 1'b1; key_code = 4'd1;
        @(negedge clk); key_code = 4'd2;
        @(negedge clk); key_code = 4'd3;
        @(negedge clk); key_valid = 1'b0; key_code = 4'd0;
        check("burst_value", 32'(entry_value), 123);
        check("burst_count", 32'(entry_count), 3);

        // Asynchronous reset in the middle of an entry.
        do_reset();
        press(4'd9); press(4'd13); press(4'd6);
        check("prereset_opa", 32'(operand_a), 9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_opa",   32'(operand_a),   0);
        check("async_op",    32'(opcode),      0);
        check("async_value", 32'(entry_value), 0);
        check("async_count", 32'(entry_count), 0);
        check("async_phase", 32'(phase),       0);
        check("async_valid", 32'(cmd_valid),   0);
        @(negedge clk);
        rst_n = 1'b1;

        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time limit so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, finish not reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_entry.md
# calc_entry

Key-entry stage for the stopwatch-calculator, sitting directly downstream of the keypad scanner. Consumes one debounced key code per press and assembles decimal operands and an operator into a complete calculator command. Presents the command to the arithmetic stage over a valid/ready handshake, and exposes the in-progress entry for the 7-segment display path.

## Interface
Parameters:
- DIGITS, 4: maximum decimal digits per operand (1..7)
- W, 14: operand width in bits; must satisfy 10^DIGITS-1 < 2^W

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle (keypad scanner's decode state)
- key_code  in  4  0-9 digit, 10 A=add, 11 B=sub, 12 C=mul, 13 D=div, 14 '#'=equals, 15 '*'=clear
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command
- operand_a  out  W  first operand, unsigned binary
- operand_b  out  W  second operand, unsigned binary
- opcode  out  2  0 add, 1 sub, 2 mul, 3 div
- entry_value  out  W  value being typed, for display
- entry_count  out  3  digits typed in current operand
- phase  out  2  0 ENTER_A, 1 ENTER_B, 2 ISSUE

## Operation
- Reset: state ENTER_A; every output 0, including cmd_valid, operand_a, operand_b, opcode, entry_value, entry_count and phase.
- Accumulator acc (W bits) and count drive entry_value and entry_count directly.
- Digit key in ENTER_A or ENTER_B:
  - if count == DIGITS: ignored.
  - if digit 0 and count == 0: ignored (no leading zeros; acc stays 0).
  - else: acc <= acc*10 + d, count <= count+1.
  - No overflow possible, given the W constraint.
- Operator key (A-D):
  - ENTER_A: operand_a <= acc, opcode <= key-10, acc/count cleared, -> ENTER_B. Works with count 0 (operand_a = 0).
  - ENTER_B with count == 0: opcode replaced.
  - ENTER_B with count > 0: ignored.
- '#':
  - ENTER_A: ignored.
  - ENTER_B: operand_b <= acc, -> ISSUE, cmd_valid <= 1.
- '*' in ENTER_A/ENTER_B: full clear (acc, count, operand_a, operand_b, opcode to 0; -> ENTER_A). See Configuration.
- ISSUE:
  - cmd_valid held high; operand_a, operand_b and opcode frozen.
  - All keys ignored except '*', which aborts: cmd_valid <= 0, full clear, -> ENTER_A.
  - Handshake (cmd_valid & cmd_ready at a rising edge): cmd_valid <= 0, full clear, -> ENTER_A.
- Simultaneous '*' and cmd_ready in ISSUE: handshake counts as completed (command transferred); end state is the same full clear.
- key_valid asserted on consecutive cycles: each strobe is processed independently.
- key_code is ignored while key_valid is low.

## Timing
- Key strobe at edge n: acc, count, phase and operands update at edge n, visible in cycle n+1.
- '#' accepted at edge n: cmd_valid high from cycle n+1.
- Handshake at edge m: cmd_valid low in cycle m+1; the next key is accepted from edge m+1 onward.
- Minimum command latency: one cycle from '#' strobe to cmd_valid.
- cmd_valid must not depend combinationally on cmd_ready.
- Reset asserted mid-operation: all state and outputs go to reset values immediately (asynchronous); any pending command is discarded.
- Deassertion of rst_n is synchronized externally.

## Configuration
- CALC_ENTRY_BACKSPACE_EN defined:
  - '*' in ENTER_A/ENTER_B with count > 0 is backspace: acc <= acc/10, count <= count-1.
  - '*' with count == 0 is a full clear.
  - '*' in ISSUE is still an abort.
- Not defined: '*' is always a full clear; no divider logic is instantiated.

## Test plan
- Keys 1,2,A,3,# then cmd_ready=1 -> cmd_valid one cycle after '#', operand_a=12, operand_b=3, opcode=0; phase=0 and entry_value=0 after the handshake.
- Keys 0,0,1,2,3,4,5 -> entry_count=4, entry_value=1234 (leading zeros and the 5th digit ignored).
- Keys 7,C,8,# with cmd_ready low for 5 cycles; digit keys 9 pressed during the wait -> cmd_valid held, operand_a=7, operand_b=8, opcode=2 stable, key 9 ignored; handshake on cycle 6.
- Keys 5,A,B,4,D,# -> opcode=1 (B replaced A at count 0; D ignored at count 1), operand_b=4.
- rst_n pulsed low after keys 9,D,6 -> all outputs 0 in the same cycle; phase=0.
- Keys 1,2,3,* -> with CALC_ENTRY_BACKSPACE_EN entry_value=12, entry_count=2, and a second '*' gives 1; without the macro entry_value=0, entry_count=0.
